// File: rtl/rsa_key_sequencer.sv
// rtl/rsa_key_sequencer.sv - RSA key setup sequencer: n/totient, range check, Euclid coprimality, generator handshake, verify
// Optional generator watchdog: define KEYSEQ_TIMEOUT_EN.
module rsa_key_sequencer #(
    parameter int INPUTSIZE      = 12,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INPUTSIZE/2-1:0] p,
    input  logic [INPUTSIZE/2-1:0] q,
    input  logic [INPUTSIZE-1:0]   e,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [INPUTSIZE-1:0]   n,
    output logic [INPUTSIZE-1:0]   d,
    output logic                   gen_rst,
    output logic [INPUTSIZE-1:0]   gen_e,
    output logic [INPUTSIZE-1:0]   gen_totient,
    input  logic [INPUTSIZE-1:0]   gen_d,
    input  logic                   gen_complete
);
    localparam int W  = INPUTSIZE;
    localparam int HW = INPUTSIZE / 2;
    localparam int W2 = 2 * INPUTSIZE;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit 16 bits");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CALC, S_CHECK, S_GCD,
        S_KICK, S_WAIT, S_VERIFY, S_DONE, S_ERR
    } state_t;

    state_t          state_q;
    logic [HW-1:0]   p_q, q_q;
    logic [W-1:0]    e_q, tot_q, a_q, b_q, gd_q;
    logic            kick_q, first_q;

    logic [HW-1:0]   pm1_d, qm1_d;
    logic [W-1:0]    n_d, tot_d;
    logic [W2-1:0]   prod_d, rem_d;
    logic            range_bad_d;

`ifdef KEYSEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]     tmo_q;
`endif

    // p,q < 2 make pm1/qm1 wrap, but range_bad_d rejects those operands first
    always_comb begin
        pm1_d       = p_q - HW'(1);
        qm1_d       = q_q - HW'(1);
        n_d         = W'(p_q) * W'(q_q);
        tot_d       = W'(pm1_d) * W'(qm1_d);
        prod_d      = W2'(e_q) * W2'(gd_q);
        rem_d       = prod_d % W2'(tot_q);
        range_bad_d = (p_q < HW'(2)) || (q_q < HW'(2)) || (e_q < W'(2)) || (e_q >= tot_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            n           <= '0;
            d           <= '0;
            gen_rst     <= 1'b1;
            gen_e       <= '0;
            gen_totient <= '0;
            p_q         <= '0;
            q_q         <= '0;
            e_q         <= '0;
            tot_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gd_q        <= '0;
            kick_q      <= 1'b0;
            first_q     <= 1'b0;
`ifdef KEYSEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    p_q     <= p;
                    q_q     <= q;
                    e_q     <= e;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    n       <= n_d;
                    tot_q   <= tot_d;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (range_bad_d) begin
                        err      <= 1'b1;
                        err_code <= 2'b01;
                        busy     <= 1'b0;
                        state_q  <= S_ERR;
                    end else begin
                        a_q     <= e_q;
                        b_q     <= tot_q;
                        state_q <= S_GCD;
                    end
                end
                S_GCD: begin
                    if (a_q == b_q) begin
                        if (a_q == W'(1)) begin
                            gen_e       <= e_q;
                            gen_totient <= tot_q;
                            gen_rst     <= 1'b1;
                            kick_q      <= 1'b0;
                            state_q     <= S_KICK;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b10;
                            busy     <= 1'b0;
                            state_q  <= S_ERR;
                        end
                    end else if (a_q > b_q) begin
                        a_q <= a_q - b_q;
                    end else begin
                        b_q <= b_q - a_q;
                    end
                end
                S_KICK: begin
                    if (!kick_q) begin
                        kick_q <= 1'b1;
                    end else begin
                        gen_rst <= 1'b0;
                        first_q <= 1'b1;
`ifdef KEYSEQ_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // first_q masks a complete left over from the previous generator run
                    first_q <= 1'b0;
                    if (!first_q && gen_complete) begin
                        gd_q    <= gen_d;
                        state_q <= S_VERIFY;
                    end
`ifdef KEYSEQ_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        busy     <= 1'b0;
                        gen_rst  <= 1'b1;
                        state_q  <= S_ERR;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
`endif
                end
                S_VERIFY: begin
                    gen_rst <= 1'b1;
                    busy    <= 1'b0;
                    if (rem_d == W2'(1)) begin
                        d       <= gd_q;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        state_q  <= S_ERR;
                    end
                end
                default: begin
                    if (start) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        state_q  <= S_LOAD;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_key_sequencer.sv
// tb/tb_rsa_key_sequencer.sv - self-checking bench for rsa_key_sequencer with behavioural generator
module tb_rsa_key_sequencer;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [5:0]  p, q;
    logic [11:0] e;
    logic        busy, done, err, gen_rst, gen_complete = 1'b0;
    logic [1:0]  err_code;
    logic [11:0] n, d, gen_e, gen_totient, gen_d = '0;

    int errors = 0;
    int checks = 0;
    int gmode  = 0;
    int gdelay = 0;
    int gcnt   = 0;

    rsa_key_sequencer #(.INPUTSIZE(12), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .start(start), .p(p), .q(q), .e(e),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .n(n), .d(d), .gen_rst(gen_rst), .gen_e(gen_e), .gen_totient(gen_totient),
        .gen_d(gen_d), .gen_complete(gen_complete)
    );

    always #5 clk = ~clk;

    function automatic int inv(input int ee, input int t);
        for (int x = 1; x < t; x++) if ((ee * x) % t == 1) return x;
        return 0;
    endfunction

    function automatic int gcdf(input int a, input int b);
        int t;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    // generator: mode 0 correct inverse, 1 stub returning 5, 2 never completes
    always @(negedge clk) begin
        if (gen_rst) begin
            gen_complete = 1'b0;
            gcnt = 0;
        end else if (gmode != 2) begin
            if (gcnt >= gdelay && !gen_complete) begin
                gen_d = (gmode == 0) ? 12'(inv(int'(gen_e), int'(gen_totient))) : 12'd5;
                gen_complete = 1'b1;
            end
            gcnt++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic kick_off(input int pp, input int qq, input int ee, input int gm, input int dly);
        @(negedge clk);
        gmode = gm; gdelay = dly;
        p = 6'(pp); q = 6'(qq); e = 12'(ee); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int pp, input int qq, input int ee, input int gm, input int dly,
                       output int cyc, output bit kicked);
        kick_off(pp, qq, ee, gm, dly);
        chk("busy_after_start", int'(busy), 1);
        cyc = 0; kicked = 0;
        while (busy && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!gen_rst) kicked = 1;
        end
        chk("busy_end", int'(busy), 0);
        if (busy) do_reset();
    endtask

    // reference: outcome from the key-setup rules using plain arithmetic
    task automatic model(input int pp, input int qq, input int ee, input int gm,
                         output bit x_done, output int x_code, output int x_n, inout int x_d);
        int tot;
        x_n = pp * qq; x_done = 0;
        tot = (pp >= 2 && qq >= 2) ? (pp - 1) * (qq - 1) : 0;
        if (pp < 2 || qq < 2 || ee < 2 || ee >= tot) x_code = 1;
        else if (gcdf(ee, tot) != 1) x_code = 2;
        else if (gm == 0) begin x_code = 0; x_done = 1; x_d = inv(ee, tot); end
        else if ((ee * 5) % tot == 1) begin x_code = 0; x_done = 1; x_d = 5; end
        else x_code = 3;
    endtask

    typedef struct {
        int p, q, e, gm, dly;
        bit exp_done;
        int exp_code, exp_n, exp_d;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int cyc, k, md, xc, xn, pp, qq, ee, tot;
        bit kicked, xd;

        rst = 1'b0; start = 1'b0; p = '0; q = '0; e = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_n", int'(n), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_gen_e", int'(gen_e), 0);
        chk("rst_gen_totient", int'(gen_totient), 0);
        chk("rst_gen_rst", int'(gen_rst), 1);
        rst = 1'b1;

        tbl[0] = '{p: 3, q: 11, e: 3,  gm: 1, dly: 0, exp_done: 0, exp_code: 3, exp_n: 33, exp_d: 0};
        tbl[1] = '{p: 1, q: 11, e: 3,  gm: 0, dly: 0, exp_done: 0, exp_code: 1, exp_n: 11, exp_d: 0};
        tbl[2] = '{p: 5, q: 11, e: 4,  gm: 0, dly: 0, exp_done: 0, exp_code: 2, exp_n: 55, exp_d: 0};
        tbl[3] = '{p: 3, q: 11, e: 3,  gm: 0, dly: 3, exp_done: 1, exp_code: 0, exp_n: 33, exp_d: 7};
        tbl[4] = '{p: 5, q: 11, e: 40, gm: 0, dly: 0, exp_done: 0, exp_code: 1, exp_n: 55, exp_d: 7};

        foreach (tbl[i]) begin
            run(tbl[i].p, tbl[i].q, tbl[i].e, tbl[i].gm, tbl[i].dly, cyc, kicked);
            chk($sformatf("v%0d_done", i), int'(done), int'(tbl[i].exp_done));
            chk($sformatf("v%0d_err", i), int'(err), int'(tbl[i].exp_code != 0));
            chk($sformatf("v%0d_err_code", i), int'(err_code), tbl[i].exp_code);
            chk($sformatf("v%0d_n", i), int'(n), tbl[i].exp_n);
            chk($sformatf("v%0d_d", i), int'(d), tbl[i].exp_d);
            chk($sformatf("v%0d_kicked", i), int'(kicked),
                int'(tbl[i].exp_code == 0 || tbl[i].exp_code == 3));
            chk($sformatf("v%0d_gen_rst_parked", i), int'(gen_rst), 1);
            if (tbl[i].exp_code == 1) chk($sformatf("v%0d_range_latency", i), cyc, 3);
        end

        // start pulsed during GCD must not disturb the running setup
        kick_off(3, 11, 3, 0, 2);
        repeat (4) @(negedge clk);
        p = 6'd1; e = 12'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("gcd_restart_busy", int'(busy), 0);
        chk("gcd_restart_done", int'(done), 1);
        chk("gcd_restart_n", int'(n), 33);
        chk("gcd_restart_d", int'(d), 7);

        // reset asserted while waiting on the generator
        kick_off(3, 11, 3, 2, 0);
        cyc = 0;
        while (gen_rst && cyc < 200) begin @(negedge clk); cyc++; end
        chk("wait_entered", int'(gen_rst), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_gen_rst", int'(gen_rst), 1);
        chk("midrst_d", int'(d), 0);
        chk("midrst_gen_e", int'(gen_e), 0);
        @(negedge clk);
        rst = 1'b1;
        run(3, 11, 3, 0, 1, cyc, kicked);
        chk("after_rst_done", int'(done), 1);
        chk("after_rst_d", int'(d), 7);

        // generator that never completes
        kick_off(3, 11, 3, 2, 0);
        cyc = 0;
        while (gen_rst && cyc < 200) begin @(negedge clk); cyc++; end
        chk("tmo_wait_entered", int'(gen_rst), 0);
        k = 0;
`ifdef KEYSEQ_TIMEOUT_EN
        while (!err && k < 300) begin @(negedge clk); k++; end
        chk("timeout_cycles", k, 100);
        chk("timeout_err_code", int'(err_code), 3);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_gen_rst", int'(gen_rst), 1);
`else
        while (k < 300) begin @(negedge clk); k++; end
        chk("no_timeout_busy", int'(busy), 1);
        chk("no_timeout_err", int'(err), 0);
`endif
        do_reset();

        md = 0;
        for (int it = 0; it < 25; it++) begin
            pp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 31));
            qq = int'($urandom_range(2, 31));
            tot = (pp >= 2) ? (pp - 1) * (qq - 1) : 40;
            ee = int'($urandom_range(0, tot + 3));
            model(pp, qq, ee, 0, xd, xc, xn, md);
            run(pp, qq, ee, 0, int'($urandom_range(0, 4)), cyc, kicked);
            chk($sformatf("rnd%0d_done p=%0d q=%0d e=%0d", it, pp, qq, ee), int'(done), int'(xd));
            chk($sformatf("rnd%0d_err_code", it), int'(err_code), xc);
            chk($sformatf("rnd%0d_n", it), int'(n), xn);
            chk($sformatf("rnd%0d_d", it), int'(d), md);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
